// File: rtl/boolexp_sweep_if.sv
// boolexp_sweep_if: control, vector and result signals between a sweep source and boolexp_sweep_ctrl.
interface boolexp_sweep_if #(parameter int NIN = 4);
  logic start, abort, y, a, b, c, d, busy, done, pass;
  logic [(1<<NIN)-1:0] tt, expected;
  logic [NIN:0] err_cnt;
  modport master(output start, abort, y, expected, input a, b, c, d, busy, done, tt, pass, err_cnt);
  modport slave(input start, abort, y, expected, output a, b, c, d, busy, done, tt, pass, err_cnt);
endinterface

// File: rtl/boolexp_sweep_ctrl.sv
// boolexp_sweep_ctrl: exhaustive input sweep of a boolean expression, captured into a truth table.
// Golden compare (err_cnt/pass) is built only when BOOLEXP_SWEEP_COMPARE_EN is defined.
module boolexp_sweep_ctrl #(
  parameter int NIN = 4,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst_n,
  boolexp_sweep_if.slave bus
);
  localparam int TW = 1 << NIN;
  localparam logic [NIN-1:0] LAST = NIN'(TW - 1);
  localparam logic [7:0] SLAST = 8'(SETTLE - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t r_state;
  logic [NIN-1:0] r_vec;
  logic [7:0] r_cnt;
  logic r_busy, r_done;
  logic [TW-1:0] r_tt;
  logic w_go, w_smp, w_end;
  // abort outranks start in IDLE and outranks the sample in DRIVE
  assign w_go = r_state == IDLE && bus.start && !bus.abort;
  assign w_smp = r_state == DRIVE && !bus.abort && r_cnt == SLAST;
  assign w_end = w_smp && r_vec == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_tt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_state <= DRIVE;
          r_busy <= 1'b1;
          r_tt <= '0;
          r_vec <= '0;
          r_cnt <= '0;
        end
        DRIVE: if (bus.abort) begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_vec <= '0;
          r_cnt <= '0;
        end else if (w_smp) begin
          r_tt[r_vec] <= bus.y;
          r_cnt <= '0;
          if (w_end) begin
            r_state <= DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else r_vec <= r_vec + 1'b1;
        end else r_cnt <= r_cnt + 8'd1;
        DONE: begin
          r_state <= IDLE;
          r_done <= 1'b0;
          r_vec <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign {bus.a, bus.b, bus.c, bus.d} = 4'(r_vec);
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.tt = r_tt;
`ifdef BOOLEXP_SWEEP_COMPARE_EN
  localparam logic [NIN:0] ERR_MAX = (NIN+1)'(TW);
  logic [NIN:0] r_err, w_err_nxt;
  logic r_pass;
  assign w_err_nxt = (bus.y != bus.expected[r_vec] && r_err != ERR_MAX) ? r_err + 1'b1 : r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_err <= '0;
      r_pass <= 1'b0;
    end else if (w_go) begin
      r_err <= '0;
      r_pass <= 1'b0;
    end else if (w_smp) begin
      r_err <= w_err_nxt;
      if (w_end) r_pass <= w_err_nxt == '0;
    end
  assign bus.err_cnt = r_err;
  assign bus.pass = r_pass;
`else
  logic w_unused;
  assign w_unused = ^bus.expected;
  assign bus.err_cnt = '0;
  assign bus.pass = 1'b0;
`endif
endmodule

// File: doc/boolexp_sweep_ctrl.md
# boolexp_sweep_ctrl

Sequencer that drives an exhaustive input sweep into a combinational boolean-expression block and captures its output into a truth-table register. It sits between a control source and the expression datapath, replacing manual stimulus. It applies all 2^NIN input vectors in ascending order, waits a programmable settle time per vector, samples `y`, and reports completion with a one-cycle `done` pulse.

## Interface
- `NIN`, 4: number of expression inputs; supported range 1..4.
- `SETTLE`, 2: clock cycles each vector is held before `y` is sampled; supported range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `abort`  in  1  synchronous abort; highest priority outside reset.
- `a`,`b`,`c`,`d`  out  1 each  vector bits to the expression block; `a` is the MSB. Unused high-order inputs are tied 0 when NIN<4.
- `y`  in  1  expression output under test.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse at the end of a completed sweep.
- `tt`  out  2^NIN  captured truth table; bit v = `y` for vector v.
- `expected`  in  2^NIN  golden truth table (see Configuration).
- `pass`  out  1  compare result; valid while `done`=1 and held until the next start.
- `err_cnt`  out  NIN+1  number of mismatching vectors.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: vector=0, settle counter=0, `busy`=0.
  - `start`=1 → DRIVE. On the same edge, clear `tt`, `err_cnt` and `pass`.
- DRIVE: vector v drives {a,b,c,d}, `busy`=1, and the settle counter increments each cycle.
  - On the edge where counter==SETTLE-1, write `y` into `tt[v]`; under the macro, update `err_cnt`.
  - If v==2^NIN-1 → DONE. Otherwise v←v+1 and counter←0.
- DONE: `done`=1, `busy`=0, vector still shows the last value. Unconditionally → IDLE on the next edge, and vector returns to 0.
- `start` is ignored in DRIVE and DONE. No queuing.
- `abort`=1 in DRIVE → IDLE next edge.
  - No `done` pulse.
  - `tt` keeps the bits captured so far.
  - `pass` stays 0.
  - `abort` has no effect in IDLE or DONE.
- Simultaneous `start` and `abort` in IDLE: `abort` wins and the FSM stays in IDLE.
- Vector counter is NIN bits wide and never wraps inside a sweep.
- Settle counter is 8 bits wide.

## Timing
- Reset values (asynchronous assertion; release takes effect at the next edge):
  - FSM=IDLE
  - a=b=c=d=0, busy=0, done=0
  - tt=0, pass=0, err_cnt=0
- `start` sampled high at edge k:
  - Vector 0 appears after edge k; `busy` is high from edge k.
  - Vector v is sampled at edge k+(v+1)·SETTLE.
  - `done` is high for the cycle after edge k+2^NIN·SETTLE.
- With defaults, `done` asserts 32 cycles after the start edge.
- `y` must settle within SETTLE cycles of a vector change. It is sampled registered, with no combinational path from `y` to any output.
- Back-to-back sweeps: `start` may be held high. The next sweep is accepted in the IDLE cycle after DONE.
- `rst_n` asserted mid-sweep: outputs immediately take their reset values and any partial `tt` is lost.

## Configuration
- `BOOLEXP_SWEEP_COMPARE_EN` defined:
  - Each sample compares `y` with `expected[v]`; a mismatch increments `err_cnt`, which saturates at 2^NIN.
  - `pass` is set on entry to DONE iff `err_cnt`==0 after the final sample.
- Not defined:
  - `expected` is ignored.
  - `pass` and `err_cnt` are tied 0.
  - No compare logic is synthesized.

## Test plan
- Reset mid-sweep: assert `rst_n`=0 at vector 5 → all outputs read 0 immediately, FSM returns to IDLE, and no `done` pulse follows.
- Basic sweep, defaults, `y`=(a&b)|(c&~d), `start` pulsed once:
  - abcd steps 0000..1111, each held 2 cycles.
  - `done` pulses 32 cycles after the start edge.
  - `tt`=16'hF444.
- Compare path (macro defined), same expression:
  - `expected`=16'hF444 → `pass`=1, `err_cnt`=0.
  - `expected`=16'hF440 → `pass`=0, `err_cnt`=1.
- Abort after 3 vectors sampled:
  - `abort`=1 → IDLE next cycle, no `done`.
  - `tt`[2:0] is captured and `tt`[15:3]=0.
  - A subsequent `start` runs a full sweep.
- Held `start` with SETTLE=1, `y`=1 constant:
  - Two consecutive sweeps each produce `tt`=16'hFFFF.
  - `done` pulses 18 cycles apart, with one IDLE cycle between them.
- Start ignored while busy: pulse `start` at vector 7 → sweep continues unchanged and exactly one `done` pulse occurs.
